// File: rtl/instr_issue_unit_pkg.sv
// Shared ISA constants, instruction field layout and the issue-state encoding.
// Field offsets are derived from the widths so the decoder and this front end stay in step.
package instr_issue_unit_pkg;

   localparam int OP_WIDTH       = 3;
   localparam int REG_ADDR_WIDTH = 3;
   localparam int INSTR_WIDTH    = 16;
   localparam int PC_WIDTH       = 8;
   localparam int DATA_WIDTH     = 8;

   // word = {opcode, rd, rs1, rs2, 4 spare}; I-type reuses rs2+spare as imm
   localparam int RS2_LSB   = INSTR_WIDTH - OP_WIDTH - 3*REG_ADDR_WIDTH;
   localparam int RS1_LSB   = RS2_LSB + REG_ADDR_WIDTH;
   localparam int RD_LSB    = RS1_LSB + REG_ADDR_WIDTH;
   localparam int OP_LSB    = RD_LSB + REG_ADDR_WIDTH;
   localparam int IMM_WIDTH = RS2_LSB + REG_ADDR_WIDTH;

   localparam logic [OP_WIDTH-1:0] OP_SUM   = 3'b000;
   localparam logic [OP_WIDTH-1:0] OP_SUB   = 3'b001;
   localparam logic [OP_WIDTH-1:0] OP_AND   = 3'b010;
   localparam logic [OP_WIDTH-1:0] OP_XOR   = 3'b011;
   localparam logic [OP_WIDTH-1:0] OP_ITYPE = 3'b100;
   localparam logic [OP_WIDTH-1:0] OP_NOP   = 3'b110;
   localparam logic [OP_WIDTH-1:0] OP_HALT  = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_ISSUE,
      ST_HALTED
   } issue_state_e;

endpackage

// File: rtl/instr_issue_unit_fields.sv
// Pure combinational split of an instruction word into decode fields; zero latency, no flow control.
module instr_issue_unit_fields
   import instr_issue_unit_pkg::*;
(
   input  logic [INSTR_WIDTH-1:0]    word_i,
   output logic [OP_WIDTH-1:0]       opcode_o,
   output logic [REG_ADDR_WIDTH-1:0] rd_o,
   output logic [REG_ADDR_WIDTH-1:0] rs1_o,
   output logic [REG_ADDR_WIDTH-1:0] rs2_o,
   output logic [DATA_WIDTH-1:0]     imm_o
);

   assign opcode_o = word_i[OP_LSB  +: OP_WIDTH];
   assign rd_o     = word_i[RD_LSB  +: REG_ADDR_WIDTH];
   assign rs1_o    = word_i[RS1_LSB +: REG_ADDR_WIDTH];
   assign rs2_o    = word_i[RS2_LSB +: REG_ADDR_WIDTH];
   assign imm_o    = DATA_WIDTH'(word_i[IMM_WIDTH-1:0]);

endmodule

// File: rtl/instr_issue_unit.sv
// Fetch front end: one outstanding imem read, issue to decode over valid/ready.
// Fetch-to-issue_valid is mem latency + 1; a stalled issue holds its fields and blocks the next fetch.
module instr_issue_unit
   import instr_issue_unit_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [PC_WIDTH-1:0]       start_pc,
   output logic                      imem_req,
   output logic [PC_WIDTH-1:0]       imem_addr,
   input  logic                      imem_rvalid,
   input  logic [INSTR_WIDTH-1:0]    imem_rdata,
   input  logic                      redirect_valid,
   input  logic [PC_WIDTH-1:0]       redirect_pc,
   output logic                      issue_valid,
   input  logic                      issue_ready,
   output logic [OP_WIDTH-1:0]       issue_opcode,
   output logic [REG_ADDR_WIDTH-1:0] issue_rd,
   output logic [REG_ADDR_WIDTH-1:0] issue_rs1,
   output logic [REG_ADDR_WIDTH-1:0] issue_rs2,
   output logic [DATA_WIDTH-1:0]     issue_imm,
   output logic [PC_WIDTH-1:0]       issue_pc,
   output logic                      halted
);

   issue_state_e           state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [PC_WIDTH-1:0]    issue_pc_q, issue_pc_d;
   logic [INSTR_WIDTH-1:0] word_q, word_d;
   logic                   discard_q, discard_d;

   // Fields decode from the latched word only, so imem_rdata never reaches issue_* directly
   instr_issue_unit_fields u_fields (
      .word_i   (word_q),
      .opcode_o (issue_opcode),
      .rd_o     (issue_rd),
      .rs1_o    (issue_rs1),
      .rs2_o    (issue_rs2),
      .imm_o    (issue_imm)
   );

   assign imem_req    = (state_q == ST_FETCH);
   assign imem_addr   = imem_req ? pc_q : '0;
   assign issue_valid = (state_q == ST_ISSUE);
   assign issue_pc    = issue_pc_q;
   assign halted      = (state_q == ST_HALTED);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      issue_pc_d = issue_pc_q;
      word_d     = word_q;
      discard_d  = discard_q;
      if (imem_rvalid) discard_d = 1'b0;

      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               pc_d    = start_pc;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // The request already on the bus uses the old pc; its reply must be dropped
            state_d = ST_WAIT;
            if (redirect_valid) begin
               pc_d      = redirect_pc;
               discard_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (discard_q || redirect_valid) begin
                  if (redirect_valid) pc_d = redirect_pc;
                  state_d = ST_FETCH;
               end else begin
                  word_d     = imem_rdata;
                  issue_pc_d = pc_q;
                  state_d    = ST_ISSUE;
               end
            end else if (redirect_valid) begin
               pc_d      = redirect_pc;
               discard_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = ST_FETCH;
            end else if (issue_ready) begin
               if (issue_opcode == OP_HALT) begin
                  state_d = ST_HALTED;
               end else begin
                  pc_d    = pc_q + 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         issue_pc_q <= '0;
         word_q     <= '0;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         issue_pc_q <= issue_pc_d;
         word_q     <= word_d;
         discard_q  <= discard_d;
      end
   end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench: memory responder with variable latency, queue-based model of fetch addresses,
// issued instructions and halt status, checked every cycle on the falling edge.
module tb_instr_issue_unit;
   import instr_issue_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  start_pc;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        issue_valid;
   logic        issue_ready;
   logic [2:0]  issue_opcode, issue_rd, issue_rs1, issue_rs2;
   logic [7:0]  issue_imm, issue_pc;
   logic        halted;

   instr_issue_unit dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .start_pc       (start_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .issue_opcode   (issue_opcode),
      .issue_rd       (issue_rd),
      .issue_rs1      (issue_rs1),
      .issue_rs2      (issue_rs2),
      .issue_imm      (issue_imm),
      .issue_pc       (issue_pc),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] mem [256];
   int          lat = 1;
   logic [7:0]  exp_addr [$];
   logic [7:0]  exp_pc   [$];
   int          req_cyc  [$];
   logic        exp_halted;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Memory: answers each request after lat cycles with a one-cycle rvalid
   logic [7:0] resp_addr;
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0;
      forever begin
         @(negedge clk);
         if (imem_req === 1'b1 && rst === 1'b0) begin
            resp_addr = imem_addr;
            @(posedge clk);
            repeat (lat - 1) @(posedge clk);
            #1 imem_rvalid = 1'b1;
            imem_rdata = mem[resp_addr];
            @(posedge clk);
            #1 imem_rvalid = 1'b0;
         end
      end
   end

   // Model: expected fetch order, expected issue order with fields taken from mem, halt tracking
   logic        pv = 1'b0, pr = 1'b0, prd = 1'b0, prst = 1'b1;
   logic [31:0] pf = '0;
   logic [15:0] cw;
   logic [7:0]  cp;
   initial begin
      exp_halted = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_halted = 1'b0;
         end else begin
            chk("halted", 32'(halted), 32'(exp_halted));
            if (exp_halted) chk("valid_while_halted", 32'(issue_valid), 0);
            if (imem_req) begin
               if (exp_addr.size() == 0) chk("req_unexpected", 32'(imem_req), 0);
               else begin
                  chk("imem_addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
                  req_cyc.push_back(cyc);
               end
            end
            if (pv && !pr && !prd && !prst) begin
               chk("hold_valid", 32'(issue_valid), 1);
               chk("hold_fields", {4'h0, issue_opcode, issue_rd, issue_rs1, issue_rs2, issue_imm, issue_pc}, pf);
            end
            if (issue_valid && issue_ready) begin
               if (exp_pc.size() == 0) chk("issue_unexpected", 32'(issue_valid), 0);
               else begin
                  cp = exp_pc.pop_front();
                  cw = mem[cp];
                  chk("issue_pc",     32'(issue_pc),     32'(cp));
                  chk("issue_opcode", 32'(issue_opcode), 32'(cw >> 13));
                  chk("issue_rd",     32'(issue_rd),     32'((cw >> 10) & 16'h7));
                  chk("issue_rs1",    32'(issue_rs1),    32'((cw >> 7) & 16'h7));
                  chk("issue_rs2",    32'(issue_rs2),    32'((cw >> 4) & 16'h7));
                  chk("issue_imm",    32'(issue_imm),    32'(cw & 16'h7F));
                  if (!redirect_valid && (cw >> 13) == 16'd7) exp_halted = 1'b1;
               end
            end else if (start && exp_halted) begin
               exp_halted = 1'b0;
            end
         end
         pv   = issue_valid;
         pr   = issue_ready;
         prd  = redirect_valid;
         prst = rst;
         pf   = {4'h0, issue_opcode, issue_rd, issue_rs1, issue_rs2, issue_imm, issue_pc};
      end
   end

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; issue_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_addr.delete(); exp_pc.delete(); req_cyc.delete();
   endtask

   task automatic pulse_start(input logic [7:0] pc);
      start_pc = pc; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_halted(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (halted) break;
      end
      chk(name, 32'(halted), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (issue_valid) break;
      end
      chk(name, 32'(issue_valid), 1);
   endtask

   task automatic drained(input string name);
      chk({name, "_addr_q"}, 32'(exp_addr.size()), 0);
      chk({name, "_issue_q"}, 32'(exp_pc.size()), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; start_pc = 8'h0; redirect_valid = 1'b0;
      redirect_pc = 8'h0; issue_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;

      // 1: reset, start ignored while rst is high
      start = 1'b1; start_pc = 8'h33;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_addr", 32'(imem_addr), 0);
      chk("rst_valid", 32'(issue_valid), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_fields", {4'h0, issue_opcode, issue_rd, issue_rs1, issue_rs2, issue_imm, issue_pc}, 0);
      @(posedge clk);
      #1 rst = 1'b0; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_no_req", 32'(imem_req), 0);
      end
      @(posedge clk);
      #1;

      // 2: straight line SUM, SUB, HALT at 0x10
      do_reset();
      lat = 1;
      mem[8'h10] = 16'h0530; mem[8'h11] = 16'h32E0; mem[8'h12] = 16'hE000;
      exp_addr = '{8'h10, 8'h11, 8'h12};
      exp_pc   = '{8'h10, 8'h11, 8'h12};
      pulse_start(8'h10);
      wait_valid("t2_valid", 10);
      chk("t2_opcode", 32'(issue_opcode), 0);
      chk("t2_rd", 32'(issue_rd), 1);
      chk("t2_rs1", 32'(issue_rs1), 2);
      chk("t2_rs2", 32'(issue_rs2), 3);
      chk("t2_pc", 32'(issue_pc), 32'h10);
      @(posedge clk);
      #1;
      wait_halted("t2_halt", 30);
      chk("t2_req_count", 32'(req_cyc.size()), 3);
      if (req_cyc.size() == 3) begin
         chk("t2_spacing_a", 32'(req_cyc[1] - req_cyc[0]), 3);
         chk("t2_spacing_b", 32'(req_cyc[2] - req_cyc[1]), 3);
      end
      drained("t2");

      // 3: backpressure for 5 cycles
      do_reset();
      issue_ready = 1'b0;
      mem[8'h20] = 16'h5C10; mem[8'h21] = 16'hE000;
      exp_addr = '{8'h20, 8'h21};
      exp_pc   = '{8'h20, 8'h21};
      pulse_start(8'h20);
      wait_valid("t3_valid", 10);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_bp_valid", 32'(issue_valid), 1);
         chk("t3_bp_req", 32'(imem_req), 0);
         chk("t3_bp_rd", 32'(issue_rd), 7);
      end
      @(posedge clk);
      #1 issue_ready = 1'b1;
      wait_halted("t3_halt", 30);
      drained("t3");

      // 4a: redirect during WAIT, latency 3
      do_reset();
      lat = 3;
      mem[8'h30] = 16'h6000; mem[8'h40] = 16'hE000;
      exp_addr = '{8'h30, 8'h40};
      exp_pc   = '{8'h40};
      pulse_start(8'h30);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (imem_req) seen = 1'b1;
         end
         chk("t4a_req_seen", 32'(seen), 1);
      end
      @(posedge clk);
      #1 redirect_valid = 1'b1; redirect_pc = 8'h40;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      wait_halted("t4a_halt", 40);
      drained("t4a");

      // 4b: redirect in the same cycle as rvalid
      do_reset();
      exp_addr = '{8'h30, 8'h40};
      exp_pc   = '{8'h40};
      pulse_start(8'h30);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (imem_rvalid) seen = 1'b1;
         end
         chk("t4b_rvalid_seen", 32'(seen), 1);
      end
      redirect_valid = 1'b1; redirect_pc = 8'h40;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      wait_halted("t4b_halt", 40);
      drained("t4b");

      // 5: PC wrap and I-type immediate
      do_reset();
      lat = 1;
      mem[8'hFF] = 16'h8855; mem[8'h00] = 16'hE000;
      exp_addr = '{8'hFF, 8'h00};
      exp_pc   = '{8'hFF, 8'h00};
      pulse_start(8'hFF);
      wait_valid("t5_valid", 10);
      chk("t5_imm", 32'(issue_imm), 32'h55);
      chk("t5_pc", 32'(issue_pc), 32'hFF);
      chk("t5_opcode", 32'(issue_opcode), 4);
      @(posedge clk);
      #1;
      wait_halted("t5_halt", 30);
      drained("t5");

      // 6: HALT at 5, redirect ignored while halted, restart at 0
      do_reset();
      mem[8'h05] = 16'hE000; mem[8'h00] = 16'hE000;
      exp_addr = '{8'h05};
      exp_pc   = '{8'h05};
      pulse_start(8'h05);
      wait_halted("t6_halt", 30);
      redirect_valid = 1'b1; redirect_pc = 8'h77;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t6_stay_halted", 32'(halted), 1);
         chk("t6_no_req", 32'(imem_req), 0);
      end
      @(posedge clk);
      #1;
      exp_addr.push_back(8'h00);
      exp_pc.push_back(8'h00);
      pulse_start(8'h00);
      @(negedge clk);
      chk("t6_restart_halted", 32'(halted), 0);
      chk("t6_restart_req", 32'(imem_req), 1);
      chk("t6_restart_addr", 32'(imem_addr), 0);
      @(posedge clk);
      #1;
      wait_halted("t6_halt2", 30);
      drained("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
